alu_cmd_driver: RTL and testbench

ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_ref_model.sv | 31 +++
 rtl/alu_cmd_driver.sv | 174 +++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command driver: opcode encodings (which
// also select the pushbutton) and the sequencing FSM state encodings.
// ---------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_SHR = 2'd2,
      OP_SHL = 2'd3
   } alu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_PRESS   = 3'd2,
      ST_RELEASE = 3'd3,
      ST_RESP    = 3'd4
   } state_e;

   // Phase length as loaded into an 8-bit down-counter; zero means one cycle.
   function automatic logic [7:0] phase_load(input int cycles);
      if (cycles <= 0) return 8'd1;
      else if (cycles > 255) return 8'd255;
      else return 8'(cycles);
   endfunction

endpackage

// File: rtl/alu_ref_model.sv
// ---------------------------------------------------------------------------
// alu_ref_model
// Combinational 4-bit reference of the external ALU, used to flag a captured
// result that disagrees with the operands and opcode.
// Ports:
//   op_i   opcode (add, sub, A>>B, B<<A)
//   a_i    operand A
//   b_i    operand B
//   exp_o  expected 4-bit result (all arithmetic mod 16, shifts >=4 give 0)
// ---------------------------------------------------------------------------
module alu_ref_model
   import alu_pkg::*;
(
   input  alu_op_e    op_i,
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic [3:0] exp_o
);

   always_comb begin
      exp_o = 4'd0;
      case (op_i)
         OP_ADD:  exp_o = a_i + b_i;
         OP_SUB:  exp_o = a_i - b_i;
         OP_SHR:  exp_o = a_i >> b_i;
         OP_SHL:  exp_o = b_i << a_i;
         default: exp_o = 4'd0;
      endcase
   end

endmodule

// File: rtl/alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver
// Accepts a command (op, a, b), drives the operands to a pushbutton-style ALU,
// presses the button selected by op for HOLD_CYCLES, releases for GAP_CYCLES,
// then offers the captured result on a valid/ready response port.
//
// Optional feature: define ALU_CMD_CHECK_EN to add rsp_mismatch, which compares
// the captured result against an internal reference model.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_op, cmd_a, cmd_b             command fields
//   pushbutton_one..pushbutton_four  ALU operation select lines
//   A, B                             operands to the ALU
//   result                           ALU result (combinational in the ALU)
//   rsp_valid/rsp_ready, rsp_data    response handshake and captured result
//   rsp_mismatch                     (ALU_CMD_CHECK_EN only) result check flag
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a command, cmd_ready high
// SETUP    | operands stable at A/B, no button pressed
// PRESS    | selected pushbutton held; result captured on last cycle
// RELEASE  | all buttons low before the response is offered
// RESP     | rsp_valid high until rsp_ready
// ---------------------------------------------------------------------------
module alu_cmd_driver
   import alu_pkg::*;
#(
   parameter int SETUP_CYCLES = 2,
   parameter int HOLD_CYCLES  = 3,
   parameter int GAP_CYCLES   = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   output logic       pushbutton_one,
   output logic       pushbutton_two,
   output logic       pushbutton_three,
   output logic       pushbutton_four,
   output logic [3:0] A,
   output logic [3:0] B,
   input  logic [3:0] result,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [3:0] rsp_data
`ifdef ALU_CMD_CHECK_EN
   ,
   output logic       rsp_mismatch
`endif
);

   localparam logic [7:0] SETUP_LD = phase_load(SETUP_CYCLES);
   localparam logic [7:0] HOLD_LD  = phase_load(HOLD_CYCLES);
   localparam logic [7:0] GAP_LD   = phase_load(GAP_CYCLES);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   alu_op_e    op_q;
   logic [3:0] a_q, b_q, data_q;
   // Holds cmd_ready low for the first cycle after reset release.
   logic       rdy_q;
   logic       accept, capture;

   assign accept  = cmd_valid && cmd_ready;
   assign capture = (state_q == ST_PRESS) && (cnt_q <= 8'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         op_q    <= OP_ADD;
         a_q     <= 4'd0;
         b_q     <= 4'd0;
         data_q  <= 4'd0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdy_q   <= 1'b1;
         if (accept) begin
            op_q <= alu_op_e'(cmd_op);
            a_q  <= cmd_a;
            b_q  <= cmd_b;
         end
         if (capture) data_q <= result;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SETUP;
               cnt_d   = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (cnt_q <= 8'd1) begin
               state_d = ST_PRESS;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_PRESS: begin
            if (cnt_q <= 8'd1) begin
               state_d = ST_RELEASE;
               cnt_d   = GAP_LD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_RELEASE: begin
            if (cnt_q <= 8'd1) begin
               state_d = ST_RESP;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_comb begin
      pushbutton_one   = 1'b0;
      pushbutton_two   = 1'b0;
      pushbutton_three = 1'b0;
      pushbutton_four  = 1'b0;
      if (state_q == ST_PRESS) begin
         case (op_q)
            OP_ADD:  pushbutton_one   = 1'b1;
            OP_SUB:  pushbutton_two   = 1'b1;
            OP_SHR:  pushbutton_three = 1'b1;
            OP_SHL:  pushbutton_four  = 1'b1;
            default: pushbutton_one   = 1'b0;
         endcase
      end
   end

   assign cmd_ready = (state_q == ST_IDLE) && rdy_q;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_data  = data_q;
   assign A         = a_q;
   assign B         = b_q;

`ifdef ALU_CMD_CHECK_EN
   logic [3:0] exp_val;

   alu_ref_model u_ref (
      .op_i  (op_q),
      .a_i   (a_q),
      .b_i   (b_q),
      .exp_o (exp_val)
   );

   assign rsp_mismatch = rsp_valid && (data_q != exp_val);
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

   localparam int S = 2;
   localparam int H = 3;
   localparam int G = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_a, cmd_b;
   logic       pb1, pb2, pb3, pb4;
   logic [3:0] A, B;
   logic [3:0] result;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_data;
   logic       force_zero;
`ifdef ALU_CMD_CHECK_EN
   logic       rsp_mismatch;
`endif

   always #5 clk = ~clk;

   alu_cmd_driver #(.SETUP_CYCLES(S), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
      .clk              (clk),
      .reset            (reset),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_op           (cmd_op),
      .cmd_a            (cmd_a),
      .cmd_b            (cmd_b),
      .pushbutton_one   (pb1),
      .pushbutton_two   (pb2),
      .pushbutton_three (pb3),
      .pushbutton_four  (pb4),
      .A                (A),
      .B                (B),
      .result           (result),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_data         (rsp_data)
`ifdef ALU_CMD_CHECK_EN
      ,
      .rsp_mismatch     (rsp_mismatch)
`endif
   );

   // Pushbutton-driven ALU in the environment.
   logic [3:0] pbs;
   logic [3:0] alu_out;
   assign pbs = {pb4, pb3, pb2, pb1};
   always_comb begin
      alu_out = 4'd0;
      if (pb1)      alu_out = A + B;
      else if (pb2) alu_out = A - B;
      else if (pb3) alu_out = A >> B;
      else if (pb4) alu_out = B << A;
   end
   assign result = force_zero ? 4'd0 : alu_out;

   int n_vec = 0;
   int n_err = 0;
   logic [3:0] sb_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drives one command; exp is the true ALU result for the operands.
   task automatic run_cmd(input logic [1:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] exp,
                          input int stall);
      int n, lat, pb_cnt, wrong_pb, unstable;
      logic [3:0] exp_data, held;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      rsp_ready = (stall == 0);
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      check("accept", int'(cmd_ready), 1);
      if (!cmd_ready) begin cmd_valid = 1'b0; return; end
      sb_q.push_back(force_zero ? 4'd0 : exp);
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1; pb_cnt = 0; wrong_pb = 0;
      check("operand_A", int'(A), int'(a));
      check("operand_B", int'(B), int'(b));
      while (!rsp_valid && lat < 40) begin
         if (pbs == (4'b0001 << op)) pb_cnt++;
         else if (pbs != 4'd0) wrong_pb++;
         @(negedge clk);
         lat++;
      end
      check("rsp_valid_rise", int'(rsp_valid), 1);
      // Counted from the acceptance cycle (cycle 0).
      check("rsp_latency", lat, S + H + G + 1);
      check("press_cycles", pb_cnt, H);
      check("wrong_button", wrong_pb, 0);
      if (stall > 0) begin
         held = rsp_data; unstable = 0;
         for (int i = 0; i < stall; i++) begin
            cmd_valid = 1'b1; cmd_op = ~op; cmd_a = ~a; cmd_b = ~b;
            if (!rsp_valid || rsp_data != held || cmd_ready) unstable++;
            @(negedge clk);
         end
         cmd_valid = 1'b0;
         check("stall_stable", unstable, 0);
         check("stall_ignored_A", int'(A), int'(a));
         rsp_ready = 1'b1;
      end
      exp_data = (sb_q.size() > 0) ? sb_q.pop_front() : 4'hx;
      check("rsp_data", int'(rsp_data), int'(exp_data));
`ifdef ALU_CMD_CHECK_EN
      check("rsp_mismatch", int'(rsp_mismatch), int'(exp_data != exp));
`endif
      @(negedge clk);
      check("rsp_valid_drop", int'(rsp_valid), 0);
      check("cmd_ready_back", int'(cmd_ready), 1);
   endtask

   typedef struct {
      logic [1:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{2'd0, 4'd3,  4'd4, 4'd7};
      vecs[1] = '{2'd1, 4'd2,  4'd5, 4'd13};
      vecs[2] = '{2'd3, 4'd1,  4'd9, 4'd2};
      vecs[3] = '{2'd2, 4'd8,  4'd3, 4'd1};
      vecs[4] = '{2'd0, 4'd15, 4'd1, 4'd0};
      vecs[5] = '{2'd1, 4'd0,  4'd1, 4'd15};
      vecs[6] = '{2'd2, 4'd15, 4'd4, 4'd0};
      vecs[7] = '{2'd3, 4'd3,  4'd1, 4'd8};
      vecs[8] = '{2'd3, 4'd4,  4'd1, 4'd0};

      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = 4'd0; cmd_b = 4'd0;
      rsp_ready = 1'b1; force_zero = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_cmd_ready", int'(cmd_ready), 0);
      check("reset_pbs", int'(pbs), 0);
      check("reset_AB", int'({A, B}), 0);
      check("reset_rsp_data", int'(rsp_data), 0);
      check("reset_rsp_valid", int'(rsp_valid), 0);
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_reset", int'(cmd_ready), 1);

      foreach (vecs[i]) run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

      // Response back-pressure with a busy-time command offered.
      run_cmd(2'd1, 4'd7, 4'd2, 4'd5, 10);

      // Reset in the 2nd PRESS cycle discards the command.
      begin
         int n, rose;
         @(negedge clk);
         cmd_valid = 1'b1; cmd_op = 2'd2; cmd_a = 4'd9; cmd_b = 4'd1;
         @(negedge clk);
         cmd_valid = 1'b0;
         n = 0;
         while (pbs == 4'd0 && n < 20) begin @(negedge clk); n++; end
         check("press_reached", int'(pb3), 1);
         @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         check("rst_pbs_low", int'(pbs), 0);
         check("rst_rsp_valid", int'(rsp_valid), 0);
         check("rst_rsp_data", int'(rsp_data), 0);
         check("rst_A", int'(A), 0);
         reset = 1'b0;
         @(negedge clk);
         check("rst_ready_back", int'(cmd_ready), 1);
         rose = 0;
         repeat (12) begin if (rsp_valid) rose++; @(negedge clk); end
         check("rst_no_rsp", rose, 0);
      end

      // Faulty ALU result: expected data is 0 while the true sum is 2.
      force_zero = 1'b1;
      run_cmd(2'd0, 4'd1, 4'd1, 4'd2, 0);
      force_zero = 1'b0;
      run_cmd(2'd0, 4'd1, 4'd1, 4'd2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
